// File: rtl/truth_table_pkg.sv
// Shared types and sizes for the truth-table sweep controller.
// Optional golden-compare logic is enabled with TT_CHECK_EN.
package truth_table_pkg;

    localparam int N_IN  = 4;
    localparam int N_OUT = 10;
    localparam int ROWS  = 2 ** N_IN;

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        PRESENT,
        DONE
    } tt_state_t;

    typedef struct packed {
        logic [N_IN-1:0]  idx;
        logic [N_OUT-1:0] data;
    } tt_row_t;

endpackage

// File: rtl/tt_settle_timer.sv
// Loadable down-counter that stops at zero; zero flags the end of settling.
// Load takes priority over counting.
module tt_settle_timer #(
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    output logic         zero
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (en && cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/truth_table_sequencer.sv
// Steps the board inputs through every row, settles, captures and streams rows.
// Define TT_CHECK_EN to add exp_data, mismatch and mismatch_cnt.
module truth_table_sequencer
    import truth_table_pkg::*;
#(
    parameter int SETTLE_CYCLES = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    output logic             busy,
    output logic             done,
    output logic             w,
    output logic             x,
    output logic             y,
    output logic             z,
    input  logic [N_OUT-1:0] f_in,
`ifdef TT_CHECK_EN
    input  logic [N_OUT-1:0] exp_data,
    output logic             mismatch,
    output logic [N_IN:0]    mismatch_cnt,
`endif
    output logic [N_IN-1:0]  row_idx,
    output logic [N_OUT-1:0] row_data,
    output logic             row_valid,
    input  logic             row_ready
);

    localparam int CW = $clog2(SETTLE_CYCLES + 1);
    localparam logic [CW-1:0] RELOAD = CW'(SETTLE_CYCLES - 1);
    localparam logic [N_IN-1:0] LAST_ROW = N_IN'(ROWS - 1);

    tt_state_t state_q;
    tt_state_t state_d;
    tt_row_t   row_q;
    logic      go;
    logic      load;
    logic      capture;
    logic      advance;
    logic      zero;

    tt_settle_timer #(.W(CW)) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (load),
        .load_val (RELOAD),
        .en       (state_q == SETTLE),
        .zero     (zero)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        go      = 1'b0;
        load    = 1'b0;
        capture = 1'b0;
        advance = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start && !abort) begin
                    state_d = SETTLE;
                    go      = 1'b1;
                    load    = 1'b1;
                end
            end
            SETTLE: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (zero) begin
                    state_d = PRESENT;
                    capture = 1'b1;
                end
            end
            PRESENT: begin
                // abort outranks a same-cycle handshake
                if (abort) begin
                    state_d = IDLE;
                end else if (row_ready) begin
                    if (row_q.idx == LAST_ROW) begin
                        state_d = DONE;
                    end else begin
                        state_d = SETTLE;
                        advance = 1'b1;
                        load    = 1'b1;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            row_q     <= '0;
            row_valid <= 1'b0;
        end else begin
            if (go) begin
                row_q.idx <= '0;
            end else if (advance) begin
                row_q.idx <= row_q.idx + 1'b1;
            end
            if (capture) begin
                row_q.data <= f_in;
            end
            row_valid <= (state_d == PRESENT);
        end
    end

`ifdef TT_CHECK_EN
    localparam logic [N_IN:0] CNT_SAT = (N_IN + 1)'(ROWS);

    logic miss;
    assign miss = (f_in != exp_data);

    always_ff @(posedge clk) begin
        if (rst) begin
            mismatch     <= 1'b0;
            mismatch_cnt <= '0;
        end else begin
            if (capture) begin
                mismatch <= miss;
            end else if (state_d != PRESENT) begin
                mismatch <= 1'b0;
            end
            if (go) begin
                mismatch_cnt <= '0;
            end else if (capture && miss && mismatch_cnt != CNT_SAT) begin
                mismatch_cnt <= mismatch_cnt + 1'b1;
            end
        end
    end
`endif

    assign busy         = (state_q != IDLE);
    assign done         = (state_q == DONE);
    assign {w, x, y, z} = row_q.idx;
    assign row_idx      = row_q.idx;
    assign row_data     = row_q.data;

endmodule

// File: tb/tb_truth_table_sequencer.sv
// Directed bench for truth_table_sequencer with a behavioural board model.
// Build with TT_CHECK_EN defined to also exercise the golden-compare ports.
module tb_truth_table_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       abort;
    logic       busy;
    logic       done;
    logic       w, x, y, z;
    logic [9:0] f_in;
    logic [3:0] row_idx;
    logic [9:0] row_data;
    logic       row_valid;
    logic       row_ready;
    logic       inject;
`ifdef TT_CHECK_EN
    logic [9:0] exp_data;
    logic       mismatch;
    logic [4:0] mismatch_cnt;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    function automatic logic [9:0] board(input logic [3:0] v);
        logic bw, bx, by, bz;
        {bw, bx, by, bz} = v;
        board = {v ^ 4'b1010, ^v, &v, (by & bx) | (bz & bw), v[2:0]};
    endfunction

    assign f_in = board({w, x, y, z});
`ifdef TT_CHECK_EN
    assign exp_data = board(row_idx)
        ^ {9'b0, inject && (row_idx == 4'd4 || row_idx == 4'd11)};
`endif

    truth_table_sequencer #(.SETTLE_CYCLES(6)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .abort        (abort),
        .busy         (busy),
        .done         (done),
        .w            (w),
        .x            (x),
        .y            (y),
        .z            (z),
        .f_in         (f_in),
`ifdef TT_CHECK_EN
        .exp_data     (exp_data),
        .mismatch     (mismatch),
        .mismatch_cnt (mismatch_cnt),
`endif
        .row_idx      (row_idx),
        .row_data     (row_data),
        .row_valid    (row_valid),
        .row_ready    (row_ready)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_done"}, 32'(done), 32'd0);
        check({tag, "_valid"}, 32'(row_valid), 32'd0);
        check({tag, "_idx"}, 32'(row_idx), 32'd0);
        check({tag, "_data"}, 32'(row_data), 32'd0);
        check({tag, "_wxyz"}, 32'({w, x, y, z}), 32'd0);
`ifdef TT_CHECK_EN
        check({tag, "_mm"}, 32'(mismatch), 32'd0);
        check({tag, "_mmcnt"}, 32'(mismatch_cnt), 32'd0);
`endif
    endtask

    // Full sweep with row_ready high; optional stray start at edge extra_start.
    task automatic run_sweep(input int extra_start);
        int beats   = 0;
        int first_v = -1;
        int done_at = -1;
        int n_done  = 0;
        logic [9:0] cap [16];
        start = 1'b1;
        tick();
        start = 1'b0;
        check("sw_busy_start", 32'(busy), 32'd1);
        for (int c = 1; c <= 125; c++) begin
            if (c == extra_start) start = 1'b1;
            tick();
            start = 1'b0;
            if (row_valid) begin
                if (first_v < 0) first_v = c;
                check("sw_beat_edge", 32'(c), 32'(6 + 7 * beats));
                check("sw_idx", 32'(row_idx), 32'(beats));
                check("sw_wxyz", 32'({w, x, y, z}), 32'(beats));
                check("sw_data", 32'(row_data), 32'(board(beats[3:0])));
`ifdef TT_CHECK_EN
                check("sw_mismatch", 32'(mismatch),
                      32'(inject && (beats == 4 || beats == 11)));
`endif
                if (beats < 16) cap[beats] = row_data;
                beats++;
            end
            if (done) begin
                n_done++;
                if (done_at < 0) done_at = c;
`ifdef TT_CHECK_EN
                check("sw_mmcnt", 32'(mismatch_cnt), inject ? 32'd2 : 32'd0);
`endif
            end
            if (done_at >= 0 && c == done_at + 1)
                check("sw_busy_after_done", 32'(busy), 32'd0);
        end
        check("sw_beats", 32'(beats), 32'd16);
        check("sw_first_valid", 32'(first_v), 32'd6);
        check("sw_done_edge", 32'(done_at), 32'd112);
        check("sw_done_pulses", 32'(n_done), 32'd1);
        check("sw_idx_hold", 32'(row_idx), 32'd15);
        check("sw_wxyz_hold", 32'({w, x, y, z}), 32'hF);
        check("sw_f3_r6", 32'(cap[6][3]), 32'd1);
        check("sw_f3_r7", 32'(cap[7][3]), 32'd1);
        check("sw_f3_r9", 32'(cap[9][3]), 32'd1);
        check("sw_f3_r11", 32'(cap[11][3]), 32'd1);
        check("sw_f3_r5", 32'(cap[5][3]), 32'd0);
        check("sw_f3_r10", 32'(cap[10][3]), 32'd0);
    endtask

    initial begin
        int found;
        int bad;
        rst       = 1'b1;
        start     = 1'b0;
        abort     = 1'b0;
        row_ready = 1'b1;
        inject    = 1'b0;
        repeat (2) tick();
        check_reset_outputs("rst");
        rst = 1'b0;
        tick();

        run_sweep(0);
        tick();

        // Back-pressure at row 2
        start = 1'b1;
        tick();
        start = 1'b0;
        found = 0;
        for (int i = 0; i < 40 && found == 0; i++) begin
            tick();
            if (row_valid && row_idx == 4'd2) found = 1;
        end
        check("t2_reach", 32'(found), 32'd1);
        row_ready = 1'b0;
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (row_valid !== 1'b1 || row_idx !== 4'd2 ||
                row_data !== board(4'd2) || {w, x, y, z} !== 4'b0010)
                bad++;
        end
        check("t2_hold_bad", 32'(bad), 32'd0);
        row_ready = 1'b1;
        tick();
        check("t2_release_valid", 32'(row_valid), 32'd0);
        check("t2_release_idx", 32'(row_idx), 32'd3);

        // Abort while settling row 7
        found = 0;
        for (int i = 0; i < 60 && found == 0; i++) begin
            tick();
            if (!row_valid && row_idx == 4'd7) found = 1;
        end
        check("t3_reach", 32'(found), 32'd1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("t3_busy", 32'(busy), 32'd0);
        check("t3_valid", 32'(row_valid), 32'd0);
        check("t3_done", 32'(done), 32'd0);
        bad = 0;
        repeat (10) begin
            tick();
            if (done || busy) bad++;
        end
        check("t3_quiet", 32'(bad), 32'd0);

        // Restart from row 0 with a stray start mid-sweep
        run_sweep(20);
        tick();

        start = 1'b1;
        abort = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        check("t4_busy0", 32'(busy), 32'd0);
        tick();
        check("t4_busy1", 32'(busy), 32'd0);
        check("t4_valid", 32'(row_valid), 32'd0);

        // Reset while presenting row 9
        start = 1'b1;
        tick();
        start = 1'b0;
        found = 0;
        for (int i = 0; i < 100 && found == 0; i++) begin
            tick();
            if (row_valid && row_idx == 4'd9) found = 1;
        end
        check("t5_reach", 32'(found), 32'd1);
        rst = 1'b1;
        tick();
        check_reset_outputs("t5");
        rst = 1'b0;
        tick();

`ifdef TT_CHECK_EN
        inject = 1'b1;
        run_sweep(0);
        inject = 1'b0;
`endif

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
